// File: rtl/mem_stage_if.sv
// Bundle of MEM-stage pipeline buses and the data-SRAM read port.
// The slave side is the MEM stage; the master side is its environment.
interface mem_stage_if #(
  parameter int STALL_W      = 6,
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70
);
  logic [STALL_W-1:0]      stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [2:0]              ex_ld_op;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [37:0]             mem_to_id;
  logic                    mem_is_load;

  modport master (
    output stall,
    output ex_to_mem_bus,
    output ex_ld_op,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_id,
    input  mem_is_load
  );

  modport slave (
    input  stall,
    input  ex_to_mem_bus,
    input  ex_ld_op,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_id,
    output mem_is_load
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: EX->MEM register, load-data hold FSM, WB select.
// MEM_LOAD_EXT_EN enables sub-word load select and sign/zero extension.
module mem_stage #(
  parameter int STALL_W      = 6,
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave io
);

  localparam logic STOP = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [EX_TO_MEM_WD-1:0] bus_r;
  state_t                  state;
  logic [31:0]             rdata_buf;

  logic [31:0] pc;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic        is_load;
  logic        mem_stop;
  logic        wb_stop;
  logic [31:0] ld_data;
  logic [31:0] ld_ext;
  logic [31:0] rf_wdata;

  assign mem_stop = io.stall[3] == STOP;
  assign wb_stop  = io.stall[4] == STOP;

  assign pc         = bus_r[75:44];
  assign ram_en     = bus_r[43];
  assign ram_wen    = bus_r[42:39];
  assign sel_rf_res = bus_r[38];
  assign rf_we      = bus_r[37];
  assign rf_waddr   = bus_r[36:32];
  assign ex_result  = bus_r[31:0];
  assign is_load    = ram_en & ~|ram_wen;

`ifdef MEM_LOAD_EXT_EN
  logic [2:0] ld_op_r;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  // Pipeline register with bubble insertion when MEM stalls but WB drains.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_r   <= '0;
      ld_op_r <= '0;
    end else if (mem_stop && !wb_stop) begin
      bus_r   <= '0;
      ld_op_r <= '0;
    end else if (!mem_stop) begin
      bus_r   <= io.ex_to_mem_bus;
      ld_op_r <= io.ex_ld_op;
    end
  end

  // Sub-word select and extension; unknown op codes act as LW.
  always_comb begin
    ld_byte = ld_data[7:0];
    unique case (ex_result[1:0])
      2'd0: ld_byte = ld_data[7:0];
      2'd1: ld_byte = ld_data[15:8];
      2'd2: ld_byte = ld_data[23:16];
      2'd3: ld_byte = ld_data[31:24];
      default: ld_byte = ld_data[7:0];
    endcase
    ld_half = ex_result[1] ? ld_data[31:16] : ld_data[15:0];
    case (ld_op_r)
      3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_ext = {24'd0, ld_byte};
      3'b011:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {16'd0, ld_half};
      default: ld_ext = ld_data;
    endcase
  end
`else
  // Pipeline register with bubble insertion when MEM stalls but WB drains.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_r <= '0;
    end else if (mem_stop && !wb_stop) begin
      bus_r <= '0;
    end else if (!mem_stop) begin
      bus_r <= io.ex_to_mem_bus;
    end
  end

  assign ld_ext = ld_data;
`endif

  // Hold FSM: the SRAM drops rdata during a stall, so keep a private copy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rdata_buf <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_load && mem_stop) begin
            rdata_buf <= io.data_sram_rdata;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!mem_stop) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ld_data  = (state == HOLD) ? rdata_buf : io.data_sram_rdata;
  assign rf_wdata = sel_rf_res ? ld_ext : ex_result;

  assign io.mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign io.mem_to_id     = {rf_we, rf_waddr, rf_wdata};
  assign io.mem_is_load   = is_load;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU path, load hold, bubbles.
// Expectations follow MEM_LOAD_EXT_EN the same way the design does.
module tb_mem_stage;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .io  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [31:0] pc,
    input logic        en,
    input logic [3:0]  wen,
    input logic        sel,
    input logic        we,
    input logic [4:0]  waddr,
    input logic [31:0] res,
    input logic [2:0]  op
  );
    bus_if.ex_to_mem_bus = {pc, en, wen, sel, we, waddr, res};
    bus_if.ex_ld_op      = op;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_if.stall           = 6'($urandom);
      bus_if.ex_to_mem_bus   = {12'($urandom), 32'($urandom), 32'($urandom)};
      bus_if.ex_ld_op        = 3'($urandom);
      bus_if.data_sram_rdata = 32'($urandom);
      step();
      total++;
      if (bus_if.mem_to_wb_bus !== 70'd0) begin
        bad++;
        $display("FAIL reset_wb got=%h want=0", bus_if.mem_to_wb_bus);
      end
      total++;
      if (bus_if.mem_to_id !== 38'd0) begin
        bad++;
        $display("FAIL reset_id got=%h want=0", bus_if.mem_to_id);
      end
      total++;
      if (bus_if.mem_is_load !== 1'b0) begin
        bad++;
        $display("FAIL reset_isld got=%b want=0", bus_if.mem_is_load);
      end
    end
    rst = 1'b1;
    bus_if.stall = 6'd0;
    drive(32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0);
    step();
  endtask

  task automatic test_alu();
    drive(32'h40, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 3'd0);
    bus_if.data_sram_rdata = 32'hCAFEF00D;
    step();
    total++;
    if (bus_if.mem_to_id !== {1'b1, 5'd5, 32'h1234}) begin
      bad++;
      $display("FAIL alu_id got=%h want=%h", bus_if.mem_to_id,
               {1'b1, 5'd5, 32'h1234});
    end
    total++;
    if (bus_if.mem_to_wb_bus !== {32'h40, 1'b1, 5'd5, 32'h1234}) begin
      bad++;
      $display("FAIL alu_wb got=%h want=%h", bus_if.mem_to_wb_bus,
               {32'h40, 1'b1, 5'd5, 32'h1234});
    end
    total++;
    if (bus_if.mem_is_load !== 1'b0) begin
      bad++;
      $display("FAIL alu_isld got=%b want=0", bus_if.mem_is_load);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h44, 1'b0, 4'd0, 1'b0, 1'b1, 5'd9, 32'hAAAA5555, 3'd0);
    step();
    drive(32'h48, 1'b1, 4'hF, 1'b0, 1'b0, 5'd3, 32'h00000204, 3'd0);
    total++;
    if (bus_if.mem_to_id !== {1'b1, 5'd9, 32'hAAAA5555}) begin
      bad++;
      $display("FAIL b2b_first got=%h want=%h", bus_if.mem_to_id,
               {1'b1, 5'd9, 32'hAAAA5555});
    end
    step();
    total++;
    if (bus_if.mem_to_wb_bus !== {32'h48, 1'b0, 5'd3, 32'h204}) begin
      bad++;
      $display("FAIL b2b_store got=%h want=%h", bus_if.mem_to_wb_bus,
               {32'h48, 1'b0, 5'd3, 32'h204});
    end
    total++;
    if (bus_if.mem_is_load !== 1'b0) begin
      bad++;
      $display("FAIL b2b_store_isld got=%b want=0", bus_if.mem_is_load);
    end
  endtask

  task automatic test_hold();
    drive(32'h50, 1'b0, 4'd0, 1'b0, 1'b1, 5'd11, 32'h77, 3'd0);
    step();
    bus_if.stall = 6'b011111;
    drive(32'h54, 1'b0, 4'd0, 1'b0, 1'b1, 5'd12, 32'h88, 3'd0);
    step();
    step();
    total++;
    if (bus_if.mem_to_id !== {1'b1, 5'd11, 32'h77}) begin
      bad++;
      $display("FAIL hold_alu got=%h want=%h", bus_if.mem_to_id,
               {1'b1, 5'd11, 32'h77});
    end
    bus_if.stall = 6'd0;
    step();
    total++;
    if (bus_if.mem_to_id !== {1'b1, 5'd12, 32'h88}) begin
      bad++;
      $display("FAIL hold_release got=%h want=%h", bus_if.mem_to_id,
               {1'b1, 5'd12, 32'h88});
    end
  endtask

  task automatic test_load_hold();
    drive(32'h60, 1'b1, 4'd0, 1'b1, 1'b1, 5'd7, 32'h100, 3'd0);
    bus_if.data_sram_rdata = 32'd0;
    step();
    bus_if.data_sram_rdata = 32'hDEADBEEF;
    bus_if.stall = 6'b011111;
    drive(32'h64, 1'b0, 4'd0, 1'b0, 1'b1, 5'd8, 32'h5A5A, 3'd0);
    #1;
    total++;
    if (bus_if.mem_to_wb_bus[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL ldh_live got=%h want=deadbeef",
               bus_if.mem_to_wb_bus[31:0]);
    end
    total++;
    if (bus_if.mem_is_load !== 1'b1) begin
      bad++;
      $display("FAIL ldh_isld got=%b want=1", bus_if.mem_is_load);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      bus_if.data_sram_rdata = 32'd0;
      #1;
      total++;
      if (bus_if.mem_to_wb_bus !== {32'h60, 1'b1, 5'd7, 32'hDEADBEEF}) begin
        bad++;
        $display("FAIL ldh_stall%0d got=%h want=%h", i,
                 bus_if.mem_to_wb_bus, {32'h60, 1'b1, 5'd7, 32'hDEADBEEF});
      end
    end
    bus_if.stall = 6'd0;
    #1;
    total++;
    if (bus_if.mem_to_wb_bus[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL ldh_rel_edge got=%h want=deadbeef",
               bus_if.mem_to_wb_bus[31:0]);
    end
    step();
    total++;
    if (bus_if.mem_to_id !== {1'b1, 5'd8, 32'h5A5A}) begin
      bad++;
      $display("FAIL ldh_next got=%h want=%h", bus_if.mem_to_id,
               {1'b1, 5'd8, 32'h5A5A});
    end
    drive(32'h68, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h104, 3'd0);
    step();
    bus_if.data_sram_rdata = 32'h11223344;
    #1;
    total++;
    if (bus_if.mem_to_id !== {1'b1, 5'd9, 32'h11223344}) begin
      bad++;
      $display("FAIL ldh_idle got=%h want=%h", bus_if.mem_to_id,
               {1'b1, 5'd9, 32'h11223344});
    end
  endtask

  task automatic test_bubble();
    drive(32'h70, 1'b0, 4'd0, 1'b0, 1'b1, 5'd13, 32'h99, 3'd0);
    step();
    bus_if.stall = 6'b001111;
    step();
    total++;
    if (bus_if.mem_to_wb_bus !== 70'd0) begin
      bad++;
      $display("FAIL bubble_wb got=%h want=0", bus_if.mem_to_wb_bus);
    end
    total++;
    if (bus_if.mem_to_id[37] !== 1'b0) begin
      bad++;
      $display("FAIL bubble_we got=%b want=0", bus_if.mem_to_id[37]);
    end
    bus_if.stall = 6'd0;
    step();
  endtask

  task automatic test_load_ext();
    logic [31:0] exp [5];
    logic [2:0]  ops [5];
    logic [31:0] adr [5];
    ops = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    adr = '{32'h203, 32'h203, 32'h200, 32'h202, 32'h201};
`ifdef MEM_LOAD_EXT_EN
    exp = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF,
            32'h80FF7F01};
`else
    exp = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
            32'h80FF7F01};
`endif
    for (int i = 0; i < 5; i++) begin
      drive(32'h80, 1'b1, 4'd0, 1'b1, 1'b1, 5'd14, adr[i], ops[i]);
      bus_if.data_sram_rdata = 32'd0;
      step();
      bus_if.data_sram_rdata = 32'h80FF7F01;
      #1;
      total++;
      if (bus_if.mem_to_id[31:0] !== exp[i]) begin
        bad++;
        $display("FAIL ldext_%0d got=%h want=%h", i,
                 bus_if.mem_to_id[31:0], exp[i]);
      end
    end
  endtask

  task automatic test_reset_in_hold();
    drive(32'h90, 1'b1, 4'd0, 1'b1, 1'b1, 5'd15, 32'h300, 3'd0);
    step();
    bus_if.data_sram_rdata = 32'h0BADF00D;
    bus_if.stall = 6'b011111;
    step();
    rst = 1'b0;
    step();
    total++;
    if (bus_if.mem_to_id !== 38'd0) begin
      bad++;
      $display("FAIL rsthold_id got=%h want=0", bus_if.mem_to_id);
    end
    rst = 1'b1;
    bus_if.stall = 6'd0;
    drive(32'h94, 1'b1, 4'd0, 1'b1, 1'b1, 5'd16, 32'h304, 3'd0);
    step();
    bus_if.data_sram_rdata = 32'h12345678;
    #1;
    total++;
    if (bus_if.mem_to_id !== {1'b1, 5'd16, 32'h12345678}) begin
      bad++;
      $display("FAIL rsthold_live got=%h want=%h", bus_if.mem_to_id,
               {1'b1, 5'd16, 32'h12345678});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus_if.stall           = 6'd0;
    bus_if.ex_to_mem_bus   = '0;
    bus_if.ex_ld_op        = 3'd0;
    bus_if.data_sram_rdata = 32'd0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_hold();
    test_load_hold();
    test_bubble();
    test_load_ext();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
